// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream requesters.
// Round-robin arbitration with message locking: once granted, a requester owns the UART
// until its byte flagged last has been handed over, so messages never interleave.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   req_valid_i  per-requester byte valid
//   req_data_i   per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   req_last_i   byte is the final byte of its message
//   req_ready_o  byte accepted when req_valid_i[i] && req_ready_o[i]
//   tx_data_o    byte to the UART data_in
//   tx_valid_o   to the UART data_valid
//   tx_ready_i   from the UART data_ready
//   grant_id_o   current or last owner
//   busy_o       a message is locked
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [DATA_W-1:0]          tx_data_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        StArb,
        StFetch,
        StSend,
        StDrain,
        StWaitRdy
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              last_q;
    logic              busy_q;
    logic [IdW-1:0]    grant_q;
    logic [IdW-1:0]    rr_ptr_q;

    logic [DATA_W-1:0] req_bytes [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starting just after the last finished owner.
    logic           win_found;
    logic [IdW-1:0] win_id;
    logic [IdW-1:0] cand;
    int unsigned    idx;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand = IdW'(idx);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Only the owner is ever offered ready, and only while a byte is being fetched.
    always_comb begin
        req_ready_o = '0;
        if (state_q == StFetch) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StArb;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            rr_ptr_q   <= IdW'(NUM_REQ - 1);
        end else begin
            case (state_q)
                StArb: begin
                    if (win_found) begin
                        grant_q <= win_id;
                        busy_q  <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    // An owner stall simply parks here with the lock held.
                    if (req_valid_i[grant_q]) begin
                        tx_data_q  <= req_bytes[grant_q];
                        last_q     <= req_last_i[grant_q];
                        tx_valid_q <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (tx_valid_q && tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StDrain;
                    end
                end
                StDrain: begin
                    // UART ready is registered and stays high one cycle after accept;
                    // wait for it to drop so the next byte is not taken twice.
                    if (!tx_ready_i) begin
                        state_q <= StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (tx_ready_i) begin
                        if (last_q) begin
                            busy_q   <= 1'b0;
                            rr_ptr_q <= grant_q;
                            state_q  <= StArb;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign grant_id_o = grant_q;
    assign busy_o     = busy_q;

endmodule
